// File: rtl/stream_mux_pkg.sv
// ============================================================================
// stream_mux_pkg : shared types and defaults for the stream multiplexer
// Rev 1.0
// ============================================================================
`default_nettype none

package stream_mux_pkg;

   typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mux_mode_t;

   localparam int WIDTH_DEF = 8;
   localparam int N_CH_DEF  = 4;

endpackage

`default_nettype wire

// File: rtl/stream_mux_rr_pick.sv
// ============================================================================
// rr_pick : rotating-priority encoder, first request after ptr (wrapping)
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick
   import stream_mux_pkg::*;
#(
   parameter int N_CH  = N_CH_DEF,
   parameter int SEL_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic             gnt_valid,
   output logic [SEL_W-1:0] gnt
);

   // Walk from the lowest priority (ptr itself) up to ptr+1 so the last hit wins.
   always_comb begin : p_pick
      int idx;
      gnt_valid = 1'b0;
      gnt       = '0;
      idx       = 0;
      for (int k = N_CH; k >= 1; k--) begin
         idx = (int'(ptr) + k) % N_CH;
         if (req[idx[SEL_W-1:0]]) begin
            gnt_valid = 1'b1;
            gnt       = idx[SEL_W-1:0];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/stream_mux_rr.sv
// ============================================================================
// stream_mux_rr : N-channel registered stream mux, fixed-select or round-robin.
// Optional packet lock on in_last when STREAM_MUX_LOCK_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module stream_mux_rr
   import stream_mux_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int N_CH  = N_CH_DEF,
   parameter int SEL_W = $clog2(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      sel,
   input  logic [N_CH-1:0]       in_valid,
   output logic [N_CH-1:0]       in_ready,
   input  logic [N_CH*WIDTH-1:0] in_data,
`ifdef STREAM_MUX_LOCK_EN
   input  logic [N_CH-1:0]       in_last,
   output logic                  out_last,
`endif
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [SEL_W-1:0]      out_ch
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic [SEL_W-1:0] r_ch;
   logic [SEL_W-1:0] r_ptr;

   logic             w_load;
   logic             w_xfer;
   logic             w_rr_valid;
   logic [SEL_W-1:0] w_rr_gnt;
   logic             w_fix_valid;
   logic             w_lock_active;
   logic             w_lock_valid;
   logic [SEL_W-1:0] w_lock_ch;
   logic             w_gnt_valid;
   logic [SEL_W-1:0] w_gnt;
   logic [WIDTH-1:0] w_data;

   rr_pick #(.N_CH(N_CH), .SEL_W(SEL_W)) u_pick (
      .req       (in_valid),
      .ptr       (r_ptr),
      .gnt_valid (w_rr_valid),
      .gnt       (w_rr_gnt)
   );

   assign w_load = ~r_valid | out_ready;
   assign w_xfer = w_load & w_gnt_valid;

   // Compare against each legal index so an out-of-range sel never indexes in_valid.
   always_comb begin
      w_fix_valid  = 1'b0;
      w_lock_valid = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (sel == SEL_W'(i) && in_valid[i])       w_fix_valid  = 1'b1;
         if (w_lock_ch == SEL_W'(i) && in_valid[i]) w_lock_valid = 1'b1;
      end
   end

   always_comb begin
      w_gnt_valid = 1'b0;
      w_gnt       = '0;
      if (w_lock_active) begin
         w_gnt_valid = w_lock_valid;
         w_gnt       = w_lock_ch;
      end else if (mux_mode_t'(mode) == MODE_RR) begin
         w_gnt_valid = w_rr_valid;
         w_gnt       = w_rr_gnt;
      end else begin
         w_gnt_valid = w_fix_valid;
         w_gnt       = sel;
      end
   end

   always_comb begin
      w_data = '0;
      for (int i = 0; i < N_CH; i++)
         if (w_gnt == SEL_W'(i)) w_data = in_data[i*WIDTH +: WIDTH];
   end

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ready
         assign in_ready[gi] = w_xfer & (w_gnt == SEL_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_ch    <= '0;
         r_ptr   <= SEL_W'(N_CH - 1);
      end else if (w_xfer) begin
         r_valid <= 1'b1;
         r_data  <= w_data;
         r_ch    <= w_gnt;
         r_ptr   <= w_gnt;
      end else if (w_load) begin
         r_valid <= 1'b0;
      end
   end

`ifdef STREAM_MUX_LOCK_EN
   logic             r_lock;
   logic [SEL_W-1:0] r_lock_ch;
   logic             r_last;
   logic             w_last_in;

   always_comb begin
      w_last_in = 1'b0;
      for (int i = 0; i < N_CH; i++)
         if (w_gnt == SEL_W'(i)) w_last_in = in_last[i];
   end

   // A beat without in_last pins arbitration to its channel until the packet ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lock    <= 1'b0;
         r_lock_ch <= '0;
         r_last    <= 1'b0;
      end else if (w_xfer) begin
         r_lock    <= ~w_last_in;
         r_lock_ch <= w_gnt;
         r_last    <= w_last_in;
      end
   end

   assign w_lock_active = r_lock;
   assign w_lock_ch     = r_lock_ch;
   assign out_last      = r_last;
`else
   assign w_lock_active = 1'b0;
   assign w_lock_ch     = '0;
`endif

   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign out_ch    = r_ch;

endmodule

`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
// ============================================================================
// tb_stream_mux_rr : directed + random bench for stream_mux_rr with a
// transaction-level reference model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_stream_mux_rr;
   import stream_mux_pkg::*;

   localparam int W  = 8;
   localparam int N  = 4;
   localparam int SW = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            mode;
   logic [SW-1:0]   sel;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_ready;
   logic [N*W-1:0]  in_data;
   logic            out_valid;
   logic            out_ready;
   logic [W-1:0]    out_data;
   logic [SW-1:0]   out_ch;

   logic            rst3_n = 1'b0;
   logic            mode3;
   logic [1:0]      sel3;
   logic [2:0]      in_valid3;
   logic [2:0]      in_ready3;
   logic [3*W-1:0]  in_data3;
   logic            out_valid3;
   logic            out_ready3;
   logic [W-1:0]    out_data3;
   logic [1:0]      out_ch3;
`ifdef STREAM_MUX_LOCK_EN
   logic [N-1:0]    in_last;
   logic            out_last;
   logic [2:0]      in_last3;
   logic            out_last3;
`endif

   stream_mux_rr #(.WIDTH(W), .N_CH(N)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef STREAM_MUX_LOCK_EN
      .in_last(in_last), .out_last(out_last),
`endif
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_ch(out_ch)
   );

   stream_mux_rr #(.WIDTH(W), .N_CH(3)) dut3 (
      .clk(clk), .rst_n(rst3_n), .mode(mode3), .sel(sel3),
      .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
`ifdef STREAM_MUX_LOCK_EN
      .in_last(in_last3), .out_last(out_last3),
`endif
      .out_valid(out_valid3), .out_ready(out_ready3),
      .out_data(out_data3), .out_ch(out_ch3)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   // Reference model state: what the output register should hold.
   bit         m_valid;
   logic [W-1:0] m_data;
   int         m_ch;
   int         m_ptr;
   bit         m_lock;
   int         m_lock_ch;
   bit         m_last;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = N - 1;
      m_lock = 1'b0; m_lock_ch = 0; m_last = 1'b0;
   endtask

   function automatic int grant_of();
      int g;
      g = -1;
      if (m_valid && !out_ready) return -1;
      if (m_lock) begin
         if (in_valid[m_lock_ch]) g = m_lock_ch;
      end else if (mode == MODE_FIXED) begin
         if (int'(sel) < N && in_valid[sel]) g = int'(sel);
      end else begin
         for (int k = 1; k <= N; k++)
            if (g < 0 && in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      return g;
   endfunction

   // One clock: check the combinational handshake, clock, update model, check outputs.
   task automatic cycle();
      int g;
      bit ld;
      logic [N-1:0] er;
      #1;
      g  = grant_of();
      ld = !m_valid || out_ready;
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("in_ready", 32'(in_ready), 32'(er));
      @(posedge clk);
      #1;
      if (g >= 0) begin
         m_valid = 1'b1;
         m_data  = in_data[g*W +: W];
         m_ch    = g;
         m_ptr   = g;
`ifdef STREAM_MUX_LOCK_EN
         m_lock    = !in_last[g];
         m_lock_ch = g;
         m_last    = in_last[g];
`endif
      end else if (ld) begin
         m_valid = 1'b0;
      end
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_ch", 32'(out_ch), 32'(m_ch));
`ifdef STREAM_MUX_LOCK_EN
      chk("out_last", 32'(out_last), 32'(m_last));
`endif
   endtask

   initial begin : main
      logic [W-1:0] held_d;
      logic [SW-1:0] held_c;
      logic [SW-1:0] prev;

      mode = MODE_FIXED; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
      mode3 = MODE_FIXED; sel3 = '0; in_valid3 = '0; in_data3 = '0; out_ready3 = 1'b0;
`ifdef STREAM_MUX_LOCK_EN
      in_last = '1; in_last3 = '1;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_ch", 32'(out_ch), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; rst3_n = 1'b1;
      model_reset();

      // Round robin from reset, all channels valid: ch0 first, then rotate.
      mode = MODE_RR; in_valid = 4'b1111; out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         in_data = {$urandom, $urandom};
         cycle();
         chk("rr_seq", 32'(out_ch), 32'(k % 4));
      end

      // Fixed select of channel 2.
      mode = MODE_FIXED; sel = 2'd2; in_data = {$urandom};
      in_data[2*W +: W] = 8'hA5;
      #1;
      chk("fix_ready", 32'(in_ready), 32'h4);
      cycle();
      chk("fix_data", 32'(out_data), 32'hA5);
      chk("fix_ch", 32'(out_ch), 32'd2);

      // Sparse round robin alternates between the odd channels.
      mode = MODE_RR; in_valid = 4'b1010;
      prev = out_ch;
      for (int k = 0; k < 4; k++) begin
         in_data = {$urandom};
         cycle();
         chk("rr_odd", 32'(out_ch[0]), 32'd1);
         chk("rr_alt", 32'(out_ch != prev), 32'd1);
         prev = out_ch;
      end

      // Backpressure holds the beat and blocks every input.
      in_valid = 4'b1111; out_ready = 1'b0;
      held_d = out_data; held_c = out_ch;
      for (int k = 0; k < 3; k++) begin
         in_data = {$urandom};
         cycle();
         chk("bp_data", 32'(out_data), 32'(held_d));
         chk("bp_ch", 32'(out_ch), 32'(held_c));
      end
      out_ready = 1'b1;
      #1;
      chk("bp_refill", 32'(in_ready != '0), 32'd1);
      cycle();

      // Randomized traffic against the model.
      for (int k = 0; k < 400; k++) begin
         mode      = ($urandom_range(0, 7) == 0) ? ~mode : mode;
         sel       = SW'($urandom);
         in_valid  = N'($urandom);
         in_data   = {$urandom};
         out_ready = ($urandom_range(0, 3) != 0);
`ifdef STREAM_MUX_LOCK_EN
         in_last   = N'($urandom);
`endif
         cycle();
      end

`ifdef STREAM_MUX_LOCK_EN
      // Packet lock: ch1 keeps the grant until its last beat.
      @(negedge clk); rst_n = 1'b0; #1; rst_n = 1'b1; model_reset();
      mode = MODE_RR; out_ready = 1'b1; in_valid = 4'b0001; in_last = 4'b1111;
      cycle();
      in_valid = 4'b0111; in_last = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         in_last = (k == 2) ? 4'b0010 : 4'b0000;
         in_data = {$urandom};
         cycle();
         chk("lock_ch", 32'(out_ch), (k < 3) ? 32'd1 : 32'd2);
         chk("lock_last", 32'(out_last), (k == 2) ? 32'd1 : 32'd0);
      end
`endif

      // Three-channel instance: out-of-range sel grants nothing.
      @(negedge clk);
      mode3 = MODE_FIXED; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
      in_data3 = {8'h33, 8'h22, 8'h11};
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("n3_ready", 32'(in_ready3), 32'd0);
         @(posedge clk); #1;
         chk("n3_valid", 32'(out_valid3), 32'd0);
      end
      sel3 = 2'd1; out_ready3 = 1'b0;
      @(posedge clk); #1;
      chk("n3_beat", 32'(out_valid3), 32'd1);
      chk("n3_data", 32'(out_data3), 32'h22);
      #2; rst3_n = 1'b0; #1;
      chk("n3_async_rst", 32'(out_valid3), 32'd0);

      // Asynchronous reset of the main instance while a beat is held.
      out_ready = 1'b0; in_valid = 4'b1111; mode = MODE_RR;
      @(posedge clk); #1;
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      #2; rst_n = 1'b0; #1;
      chk("async_rst", 32'(out_valid), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
